// File: rtl/data_ram_resp_if.sv
// rtl/data_ram_resp_if.sv - request/response bus between pipeline M stage and data RAM responder
interface data_ram_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        data_ok;
    logic        stall;
    logic        addr_err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, data_ok, stall, addr_err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, data_ok, stall, addr_err
    );
endinterface

// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - fixed-latency word RAM responder with stall/data_ok handshake
module data_ram_resp #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    data_ram_resp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic          r_we;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_data_ok;
    logic          r_addr_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_acc_we;
    logic [AW+1:0] w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [AW-1:0] w_idx;
    logic          w_misalign;

    // With LATENCY=1 the access completes on the acceptance edge itself, so the
    // access fields come straight from the bus while IDLE, else from the latches.
    assign w_accept     = (r_state == IDLE) && bus.req;
    assign w_enter_resp = ((r_state == WAIT) && (r_cnt == 3'd0)) || (w_accept && (LATENCY == 1));
    assign w_acc_we     = (r_state == IDLE) ? bus.we : r_we;
    assign w_acc_addr   = (r_state == IDLE) ? bus.addr[AW+1:0] : r_addr;
    assign w_acc_wdata  = (r_state == IDLE) ? bus.wdata : r_wdata;
    assign w_idx        = w_acc_addr[AW+1:2];
    assign w_misalign   = |w_acc_addr[1:0];

    assign bus.stall    = (r_state != IDLE);
    assign bus.data_ok  = r_data_ok;
    assign bus.addr_err = r_addr_err;
    assign bus.rdata    = r_rdata;

    // Control FSM: accept, count down the wait, then one-cycle response with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_data_ok  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_data_ok  <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr[AW+1:0];
                        r_wdata <= bus.wdata;
                        r_cnt   <= CNT_INIT;
                        r_state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_enter_resp) begin
                r_data_ok  <= 1'b1;
                r_addr_err <= w_misalign;
                if (!w_acc_we && !w_misalign) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Storage update on the edge entering RESP; never cleared, and gated off while in reset
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_acc_we && !w_misalign) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end
endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - scoreboard bench for data_ram_resp at LATENCY 2, 1 and 7
module tb_data_ram_resp;
    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_ok [3] = '{-1, -1, -1};
    exp_t q [3][$];

    data_ram_resp_if b2();
    data_ram_resp_if b1();
    data_ram_resp_if b7();

    data_ram_resp #(.DEPTH(256), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    data_ram_resp #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    data_ram_resp #(.DEPTH(256), .LATENCY(7)) dut7 (.clk(clk), .rst(rst), .bus(b7));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_bus(input int sel, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        case (sel)
            0: begin b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d; end
            1: begin b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d; end
            default: begin b7.req = r; b7.we = w; b7.addr = a; b7.wdata = d; end
        endcase
    endtask

    function automatic logic get_stall(input int sel);
        case (sel)
            0: return b2.stall;
            1: return b1.stall;
            default: return b7.stall;
        endcase
    endfunction

    task automatic wait_idle(input int sel);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!get_stall(sel)) done = 1;
        end
        if (!done) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Scoreboard monitor: pop and compare on every data_ok, addr_err must be low otherwise
    task automatic mon(input int idx, input logic dok, input logic err, input logic [31:0] rd, input int per);
        exp_t e;
        if (dok !== 1'b1) begin
            check($sformatf("addr_err_idle[%0d]", idx), {31'd0, err}, 32'd0);
        end else if (q[idx].size() == 0) begin
            check($sformatf("unexpected_data_ok[%0d]", idx), 32'd1, 32'd0);
        end else begin
            e = q[idx].pop_front();
            check($sformatf("addr_err[%0d]", idx), {31'd0, err}, {31'd0, e.err});
            if (e.chk_rd) check($sformatf("rdata[%0d]", idx), rd, e.rd);
            if (per > 0 && last_ok[idx] >= 0) check($sformatf("period[%0d]", idx), cyc - last_ok[idx], per);
            last_ok[idx] = cyc;
        end
    endtask

    always @(negedge clk) if (!rst) mon(0, b2.data_ok, b2.addr_err, b2.rdata, 0);
    always @(negedge clk) if (!rst) mon(1, b1.data_ok, b1.addr_err, b1.rdata, 2);
    always @(negedge clk) if (!rst) mon(2, b7.data_ok, b7.addr_err, b7.rdata, 8);

    // Issue one access on the LATENCY=2 DUT; returns at the negedge of C1
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input bit push,
                       input bit chk, input logic [31:0] er, input logic ee);
        wait_idle(0);
        set_bus(0, 1'b1, w, a, d);
        if (push) q[0].push_back('{chk, er, ee});
        @(posedge clk);
        @(negedge clk);
        set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic stream(input int sel);
        logic [31:0] wv = 32'd0;
        for (int k = 0; k < 6; k++) begin
            wait_idle(sel);
            if (k % 2 == 0) begin
                wv = 32'h5000_0000 + 32'(sel * 256 + k);
                set_bus(sel, 1'b1, 1'b1, 32'h8, wv);
                q[sel].push_back('{1'b0, 32'd0, 1'b0});
            end else begin
                set_bus(sel, 1'b1, 1'b0, 32'h8, 32'hFFFF_FFFF);
                q[sel].push_back('{1'b1, wv, 1'b0});
            end
            @(posedge clk);
        end
        @(negedge clk);
        set_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) set_bus(s, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("rst_stall", {31'd0, b2.stall}, 32'd0);
        check("rst_data_ok", {31'd0, b2.data_ok}, 32'd0);
        check("rst_rdata", b2.rdata, 32'd0);
        check("rst_addr_err", {31'd0, b2.addr_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Write then read back, with stall/data_ok timing
        acc(1'b1, 32'h10, 32'hDEADBEEF, 1, 0, 32'd0, 1'b0);
        check("c1_stall", {31'd0, b2.stall}, 32'd1);
        check("c1_data_ok", {31'd0, b2.data_ok}, 32'd0);
        @(negedge clk);
        check("c2_stall", {31'd0, b2.stall}, 32'd1);
        check("c2_data_ok", {31'd0, b2.data_ok}, 32'd1);
        acc(1'b0, 32'h10, 32'd0, 1, 1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("rd_c5_data_ok", {31'd0, b2.data_ok}, 32'd1);

        // Requests during stall are ignored
        acc(1'b1, 32'h30, 32'h33333333, 1, 0, 32'd0, 1'b0);
        acc(1'b1, 32'h20, 32'h22222222, 1, 0, 32'd0, 1'b0);
        set_bus(0, 1'b1, 1'b1, 32'h30, 32'hBAD0BAD0);
        @(negedge clk);
        set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        acc(1'b0, 32'h20, 32'd0, 1, 1, 32'h22222222, 1'b0);
        acc(1'b0, 32'h30, 32'd0, 1, 1, 32'h33333333, 1'b0);

        // Misaligned write leaves storage alone
        acc(1'b1, 32'h13, 32'h12345678, 1, 0, 32'd0, 1'b1);
        acc(1'b0, 32'h10, 32'd0, 1, 1, 32'hDEADBEEF, 1'b0);

        // Index wraps modulo DEPTH
        acc(1'b1, 32'h400, 32'hA5A5A5A5, 1, 0, 32'd0, 1'b0);
        acc(1'b0, 32'h0, 32'd0, 1, 1, 32'hA5A5A5A5, 1'b0);

        // Reset mid-WAIT discards the write, storage survives
        acc(1'b1, 32'h40, 32'h11111111, 1, 0, 32'd0, 1'b0);
        acc(1'b0, 32'h40, 32'd0, 1, 1, 32'h11111111, 1'b0);
        acc(1'b1, 32'h40, 32'h0BADF00D, 0, 0, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'd0, b2.stall}, 32'd0);
        check("midrst_data_ok", {31'd0, b2.data_ok}, 32'd0);
        check("midrst_rdata", b2.rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        acc(1'b0, 32'h40, 32'd0, 1, 1, 32'h11111111, 1'b0);

        // Back-to-back throughput at LATENCY 1 and 7
        stream(1);
        stream(2);

        repeat (12) @(negedge clk);
        for (int s = 0; s < 3; s++) check($sformatf("queue_empty[%0d]", s), 32'(q[s].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
